// File: rtl/ctrl_encode_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_encode_pkg
// Purpose : Shared encodings for the load-data extension path.
//           - Access size (mem_op): word / byte / half. 2'b11 is reserved and
//             decoded as word by its users.
//           - Extension mode (mem_ext / ext_op): zero or sign.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package ctrl_encode_pkg;

    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage : ctrl_encode_pkg

// File: rtl/ext_16_32.sv
// ----------------------------------------------------------------------------
// ext_16_32
// Purpose : Combinational 16-to-32-bit extender.
// Ports   : in16   [15:0] input  halfword to extend
//           ext_op         input  EXT_ZERO / EXT_SIGN
//           out32  [31:0]  output extended value
// ----------------------------------------------------------------------------
module ext_16_32
    import ctrl_encode_pkg::*;
(
    input  logic [15:0] in16,
    input  logic        ext_op,
    output logic [31:0] out32
);

    logic fill;

    assign fill  = (ext_op == EXT_SIGN) & in16[15];
    assign out32 = {{16{fill}}, in16};

endmodule : ext_16_32

// File: rtl/ext_8_32.sv
// ----------------------------------------------------------------------------
// ext_8_32
// Purpose : Combinational 8-to-32-bit extender.
// Ports   : in8    [7:0]  input  byte to extend
//           ext_op        input  EXT_ZERO / EXT_SIGN
//           out32  [31:0] output extended value
// ----------------------------------------------------------------------------
module ext_8_32
    import ctrl_encode_pkg::*;
(
    input  logic [7:0]  in8,
    input  logic        ext_op,
    output logic [31:0] out32
);

    logic fill;

    // Zero extension never propagates the MSB into the upper bits.
    assign fill  = (ext_op == EXT_SIGN) & in8[7];
    assign out32 = {{24{fill}}, in8};

endmodule : ext_8_32

// File: rtl/ext_8_16_32.sv
// ----------------------------------------------------------------------------
// ext_8_16_32
// Purpose : Load-data extension stage between the data-memory read port and
//           register write-back. Selects the addressed byte/halfword from an
//           aligned little-endian word, zero- or sign-extends it to 32 bits,
//           and registers the result together with a misalignment flag.
//           Latency is one cycle.
// Ports   : clk              input  rising-edge clock
//           rst              input  synchronous active-high reset
//           in_valid         input  qualifies the inputs this cycle
//           mem_op     [1:0] input  access size (MEM_WORD/MEM_BYTE/MEM_HALF,
//                                   2'b11 treated as word)
//           mem_ext          input  0 = zero-extend, 1 = sign-extend
//           offset     [1:0] input  byte offset within the word
//           word_in   [31:0] input  aligned memory word
//           out_valid        output registered copy of in_valid
//           dout      [31:0] output registered extended result
//           misaligned       output registered alignment-error flag
// ----------------------------------------------------------------------------
module ext_8_16_32
    import ctrl_encode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  mem_op,
    input  logic        mem_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] word_in,
    output logic        out_valid,
    output logic [31:0] dout,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_ext;
    logic [31:0] half_ext;

    logic        vld_q;
    logic [31:0] dout_q,  dout_d;
    logic        mis_q,   mis_d;

    // Byte lane select: little-endian, lane 0 in bits [7:0].
    always_comb begin
        byte_sel = word_in[7:0];
        case (offset)
            2'd0:    byte_sel = word_in[7:0];
            2'd1:    byte_sel = word_in[15:8];
            2'd2:    byte_sel = word_in[23:16];
            default: byte_sel = word_in[31:24];
        endcase
    end

    // Halfword lane select: offset[1] picks the upper half; offset[0]
    // is a misalignment and is handled in the size mux.
    assign half_sel = offset[1] ? word_in[31:16] : word_in[15:0];

    ext_8_32 u_ext8 (
        .in8    (byte_sel),
        .ext_op (mem_ext),
        .out32  (byte_ext)
    );

    ext_16_32 u_ext16 (
        .in16   (half_sel),
        .ext_op (mem_ext),
        .out32  (half_ext)
    );

    // Size mux and misalignment. Misaligned halfwords return zero; a
    // misaligned word still passes the raw word through with the flag set.
    always_comb begin
        dout_d = word_in;
        mis_d  = 1'b0;
        case (mem_op)
            MEM_BYTE: begin
                dout_d = byte_ext;
                mis_d  = 1'b0;
            end
            MEM_HALF: begin
                if (offset[0]) begin
                    dout_d = 32'h0;
                    mis_d  = 1'b1;
                end else begin
                    dout_d = half_ext;
                    mis_d  = 1'b0;
                end
            end
            default: begin  // MEM_WORD and reserved 2'b11
                dout_d = word_in;
                mis_d  = (offset != 2'd0);
            end
        endcase
    end

    // Output registers: data and flag only load on a valid access.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dout_q <= 32'h0;
            mis_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                dout_q <= dout_d;
                mis_q  <= mis_d;
            end
        end
    end

    assign out_valid  = vld_q;
    assign dout       = dout_q;
    assign misaligned = mis_q;

endmodule : ext_8_16_32

// File: tb/tb_ext_8_16_32.sv
// ----------------------------------------------------------------------------
// tb_ext_8_16_32
// Purpose : Directed, table-driven bench for ext_8_16_32 with hand-computed
//           expected values, plus hand-written reset/hold sequences.
// ----------------------------------------------------------------------------
module tb_ext_8_16_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  mem_op;
    logic        mem_ext;
    logic [1:0]  offset;
    logic [31:0] word_in;
    logic        out_valid;
    logic [31:0] dout;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    ext_8_16_32 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .mem_op     (mem_op),
        .mem_ext    (mem_ext),
        .offset     (offset),
        .word_in    (word_in),
        .out_valid  (out_valid),
        .dout       (dout),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        ext;
        logic [1:0]  off;
        logic [31:0] word;
        logic [31:0] exp_dout;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, clock them in, then sample #1 after the edge.
    task automatic step(input logic v, input logic [1:0] op, input logic ext,
                        input logic [1:0] off, input logic [31:0] w);
        in_valid = v;
        mem_op   = op;
        mem_ext  = ext;
        offset   = off;
        word_in  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [31:0] d, input logic m);
        check({name, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
        check({name, ".dout"}, dout, d);
        check({name, ".misaligned"}, {31'b0, misaligned}, {31'b0, m});
    endtask

    initial begin
        vecs.push_back('{"b_s_o0",   2'b01, 1'b1, 2'd0, 32'h80FF7F01, 32'h00000001, 1'b0});
        vecs.push_back('{"b_s_o1",   2'b01, 1'b1, 2'd1, 32'h80FF7F01, 32'h0000007F, 1'b0});
        vecs.push_back('{"b_s_o2",   2'b01, 1'b1, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"b_s_o3",   2'b01, 1'b1, 2'd3, 32'h80FF7F01, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{"b_z_o2",   2'b01, 1'b0, 2'd2, 32'h80FF7F01, 32'h000000FF, 1'b0});
        vecs.push_back('{"b_z_o3",   2'b01, 1'b0, 2'd3, 32'h80FF7F01, 32'h00000080, 1'b0});
        vecs.push_back('{"h_s_o0",   2'b10, 1'b1, 2'd0, 32'h80017FFF, 32'h00007FFF, 1'b0});
        vecs.push_back('{"h_s_o2",   2'b10, 1'b1, 2'd2, 32'h80017FFF, 32'hFFFF8001, 1'b0});
        vecs.push_back('{"h_z_o2",   2'b10, 1'b0, 2'd2, 32'h80017FFF, 32'h00008001, 1'b0});
        vecs.push_back('{"h_mis_o1", 2'b10, 1'b1, 2'd1, 32'h80017FFF, 32'h00000000, 1'b1});
        vecs.push_back('{"b_after",  2'b01, 1'b1, 2'd1, 32'h80017FFF, 32'h0000007F, 1'b0});
        vecs.push_back('{"h_mis_o3", 2'b10, 1'b0, 2'd3, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{"w_o0",     2'b00, 1'b1, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"w_o2",     2'b00, 1'b1, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1});
        vecs.push_back('{"w_z_o0",   2'b00, 1'b0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"rsv_o0",   2'b11, 1'b1, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"rsv_o1",   2'b11, 1'b0, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1});
        vecs.push_back('{"b_z_o1",   2'b01, 1'b0, 2'd1, 32'h12348756, 32'h00000087, 1'b0});
        vecs.push_back('{"h_z_o0",   2'b10, 1'b0, 2'd0, 32'h12348756, 32'h00008756, 1'b0});

        // Reset with in_valid high and an all-ones word.
        rst = 1'b1;
        step(1'b1, 2'b00, 1'b1, 2'd0, 32'hFFFFFFFF);
        check_out("rst_c1", 1'b0, 32'h0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 2'd0, 32'hFFFFFFFF);
        check_out("rst_c2", 1'b0, 32'h0, 1'b0);

        // First access after reset: one-cycle latency.
        rst = 1'b0;
        step(1'b1, 2'b00, 1'b0, 2'd0, 32'hCAFEF00D);
        check_out("first_word", 1'b1, 32'hCAFEF00D, 1'b0);

        // Back-to-back table vectors, checked one cycle after each is applied.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].op, vecs[i].ext, vecs[i].off, vecs[i].word);
            check_out(vecs[i].name, 1'b1, vecs[i].exp_dout, vecs[i].exp_mis);
        end

        // Hold: byte read of 0x42, then two idle cycles with changing inputs.
        step(1'b1, 2'b01, 1'b1, 2'd1, 32'h00004200);
        check_out("hold_load", 1'b1, 32'h00000042, 1'b0);
        step(1'b0, 2'b00, 1'b1, 2'd2, 32'hFFFFFFFF);
        check_out("hold_idle1", 1'b0, 32'h00000042, 1'b0);
        step(1'b0, 2'b10, 1'b1, 2'd1, 32'h87654321);
        check_out("hold_idle2", 1'b0, 32'h00000042, 1'b0);

        // Misaligned flag must also hold across an idle cycle.
        step(1'b1, 2'b00, 1'b0, 2'd3, 32'h01234567);
        check_out("mis_load", 1'b1, 32'h01234567, 1'b1);
        step(1'b0, 2'b01, 1'b0, 2'd0, 32'h00000000);
        check_out("mis_hold", 1'b0, 32'h01234567, 1'b1);

        // Three consecutive accesses after idle.
        step(1'b1, 2'b01, 1'b1, 2'd3, 32'hF0000000);
        check_out("b2b_1", 1'b1, 32'hFFFFFFF0, 1'b0);
        step(1'b1, 2'b10, 1'b1, 2'd0, 32'h0000C000);
        check_out("b2b_2", 1'b1, 32'hFFFFC000, 1'b0);
        step(1'b1, 2'b00, 1'b1, 2'd0, 32'h5A5A5A5A);
        check_out("b2b_3", 1'b1, 32'h5A5A5A5A, 1'b0);

        // Reset mid-stream has priority over in_valid.
        rst = 1'b1;
        step(1'b1, 2'b00, 1'b0, 2'd1, 32'h11111111);
        check_out("rst_mid", 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        step(1'b0, 2'b00, 1'b0, 2'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ext_8_16_32
